// File: rtl/dmem_responder.sv
// Single-port data memory responder: valid/ready request, fixed wait states, held response.
// Optional DMEM_ERR_CHECK_EN flags misaligned word and out-of-range accesses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic        byt;
    logic [31:0] wdata;
  } req_t;

  state_t      state;
  logic [3:0]  cnt;
  req_t        lat;
  req_t        cur;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          commit;
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic          err_c;
  logic [31:0]   rd_word;
  logic [31:0]   rdata_c;

  // With zero wait states the commit happens on the accept edge, so use the live inputs there.
  always_comb begin
    cur = lat;
    if (state == IDLE) begin
      cur.addr  = req_addr;
      cur.we    = req_we;
      cur.byt   = req_byte;
      cur.wdata = req_wdata;
    end
  end

  assign accept = (state == IDLE) && req_valid && req_ready;
  assign commit = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd1));
  assign widx   = cur.addr[AW+1:2];
  assign lane   = cur.addr[1:0];

`ifdef DMEM_ERR_CHECK_EN
  assign err_c = (!cur.byt && (lane != 2'b00)) || (cur.addr[31:AW+2] != '0);
`else
  logic unused_hi;
  assign err_c     = 1'b0;
  assign unused_hi = ^cur.addr[31:AW+2];
`endif

  assign rd_word = mem[widx];

  always_comb begin
    rdata_c = '0;
    if (!err_c && !cur.we)
      rdata_c = cur.byt ? {24'd0, rd_word[{lane, 3'b000} +: 8]} : rd_word;
  end

  // Storage is never reset; rst gates the write so an edge during reset cannot commit.
  always_ff @(posedge clk) begin
    if (commit && rst && cur.we && !err_c) begin
      if (cur.byt) mem[widx][{lane, 3'b000} +: 8] <= cur.wdata[7:0];
      else         mem[widx]                      <= cur.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat       <= cur;
            cnt       <= 4'(WAIT_CYCLES);
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state      <= RESP;
              cnt        <= '0;
              resp_valid <= 1'b1;
              resp_rdata <= rdata_c;
              resp_err   <= err_c;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state      <= RESP;
            cnt        <= '0;
            resp_valid <= 1'b1;
            resp_rdata <= rdata_c;
            resp_err   <= err_c;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 has WAIT_CYCLES=2, instance 1 has WAIT_CYCLES=0.
// Byte-level reference memory per instance predicts data and error flags.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic        req_byte  [2];
  logic        resp_valid[2];
  logic        resp_ready[2];
  logic        resp_err  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] resp_rdata[2];

  int total = 0;
  int bad   = 0;

  bit [7:0] mb [2][4096];
  bit       kn [2][4096];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_we(req_we[0]), .req_byte(req_byte[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_we(req_we[1]), .req_byte(req_byte[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: little-endian byte array, 4 KiB address space per instance.
  function automatic void model(input int d, input bit we, input bit byt,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output bit er, output bit known);
    int i;
    er    = 1'b0;
    rd    = '0;
    known = 1'b1;
`ifdef DMEM_ERR_CHECK_EN
    er = (!byt && (a[1:0] != 2'b00)) || (a >= 32'd4096);
`endif
    if (er) return;
    i = int'(a[11:0]);
    if (!byt) i = i & ~3;
    if (we) begin
      if (byt) begin
        mb[d][i] = wd[7:0];
        kn[d][i] = 1'b1;
      end else begin
        for (int k = 0; k < 4; k++) begin
          mb[d][i+k] = wd[8*k +: 8];
          kn[d][i+k] = 1'b1;
        end
      end
    end else if (byt) begin
      rd    = {24'd0, mb[d][i]};
      known = kn[d][i];
    end else begin
      for (int k = 0; k < 4; k++) begin
        rd[8*k +: 8] = mb[d][i+k];
        known        = known & kn[d][i+k];
      end
    end
  endfunction

  // Called #1 after a rising edge with the instance idle; returns #1 after the handshake edge.
  task automatic txn(input int d, input bit we, input bit byt, input logic [31:0] a,
                     input logic [31:0] wd, input int hold, input string tag,
                     output logic [31:0] got, output logic got_err);
    logic [31:0] rd, rd0;
    bit er, known;
    int lat, exp_lat;
    exp_lat = (d == 0) ? 3 : 1;
    model(d, we, byt, a, wd, rd, er, known);
    chk({tag, ".req_ready_idle"}, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_we[d] = we; req_byte[d] = byt;
    req_addr[d]  = a;    req_wdata[d] = wd;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_addr[d]  = $urandom; req_wdata[d] = $urandom;
    req_we[d]    = 1'($urandom_range(0, 1)); req_byte[d] = 1'($urandom_range(0, 1));
    lat = 1;
    while (!resp_valid[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".resp_valid"}, 32'(resp_valid[d]), 32'd1);
    if (known) chk({tag, ".rdata"}, resp_rdata[d], rd);
    chk({tag, ".err"}, 32'(resp_err[d]), 32'(er));
    got     = resp_rdata[d];
    got_err = resp_err[d];
    rd0     = resp_rdata[d];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(resp_valid[d]), 32'd1);
      chk({tag, ".hold_rdata"}, resp_rdata[d], rd0);
      chk({tag, ".hold_req_ready"}, 32'(req_ready[d]), 32'd0);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    chk({tag, ".post_valid"}, 32'(resp_valid[d]), 32'd0);
    chk({tag, ".post_req_ready"}, 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, a, wd;
    logic        ge;
    bit          we, byt;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_byte[d] = 1'b0;
      req_addr[d]  = '0;   req_wdata[d] = '0; resp_ready[d] = 1'b0;
    end
    #8;
    for (int d = 0; d < 2; d++) begin
      chk("reset.req_ready", 32'(req_ready[d]), 32'd1);
      chk("reset.resp_valid", 32'(resp_valid[d]), 32'd0);
      chk("reset.rdata", resp_rdata[d], 32'd0);
      chk("reset.err", 32'(resp_err[d]), 32'd0);
    end
    #4 rst = 1'b1;
    @(posedge clk); #1;

    txn(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 0, "sw10", got, ge);
    txn(0, 1'b0, 1'b0, 32'h10, 32'h0, 0, "lw10", got, ge);
    chk("lw10.const", got, 32'hDEADBEEF);
    chk("lw10.err0", 32'(ge), 32'd0);

    txn(0, 1'b1, 1'b0, 32'h10, 32'h11223344, 0, "sw10b", got, ge);
    txn(0, 1'b1, 1'b1, 32'h11, 32'h000000A5, 1, "sb11", got, ge);
    chk("sb11.rdata0", got, 32'd0);
    txn(0, 1'b0, 1'b0, 32'h10, 32'h0, 0, "lw10b", got, ge);
    chk("lw10b.const", got, 32'h1122A544);
    txn(0, 1'b0, 1'b1, 32'h11, 32'h0, 0, "lbu11", got, ge);
    chk("lbu11.const", got, 32'h000000A5);

    txn(1, 1'b1, 1'b0, 32'h40, 32'hCAFEF00D, 0, "w0.sw40", got, ge);
    txn(1, 1'b0, 1'b0, 32'h40, 32'h0, 5, "w0.lw40", got, ge);
    chk("w0.lw40.const", got, 32'hCAFEF00D);

    // Reset mid-WAIT must abort the pending store.
    txn(0, 1'b1, 1'b0, 32'h20, 32'h12345678, 0, "sw20", got, ge);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_byte[0] = 1'b0;
    req_addr[0]  = 32'h20; req_wdata[0] = 32'h55;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstwait.req_ready", 32'(req_ready[0]), 32'd1);
    chk("rstwait.resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("rstwait.rdata", resp_rdata[0], 32'd0);
    chk("rstwait.err", 32'(resp_err[0]), 32'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    txn(0, 1'b0, 1'b0, 32'h20, 32'h0, 0, "lw20", got, ge);
    chk("lw20.const", got, 32'h12345678);

`ifdef DMEM_ERR_CHECK_EN
    txn(0, 1'b1, 1'b0, 32'h0, 32'hA0A0A0A0, 0, "sw0", got, ge);
    txn(0, 1'b0, 1'b0, 32'h12, 32'h0, 0, "lw12", got, ge);
    chk("lw12.err", 32'(ge), 32'd1);
    chk("lw12.rdata", got, 32'd0);
    txn(0, 1'b1, 1'b0, 32'h1000, 32'h99, 0, "sw1000", got, ge);
    chk("sw1000.err", 32'(ge), 32'd1);
    txn(0, 1'b0, 1'b0, 32'h0, 32'h0, 0, "lw0", got, ge);
    chk("lw0.const", got, 32'hA0A0A0A0);
`else
    txn(0, 1'b1, 1'b0, 32'h1004, 32'h77, 0, "sw1004", got, ge);
    txn(0, 1'b0, 1'b0, 32'h4, 32'h0, 0, "lw4", got, ge);
    chk("lw4.const", got, 32'h00000077);
    chk("lw4.err", 32'(ge), 32'd0);
`endif

    // Randomized phase: first make the low 256 bytes known, then mixed traffic.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 64; w++)
        txn(d, 1'b1, 1'b0, 32'(4 * w), $urandom, 0, "init", got, ge);
      for (int n = 0; n < 80; n++) begin
        we  = 1'($urandom_range(0, 1));
        byt = 1'($urandom_range(0, 1));
        a   = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
        wd  = $urandom;
        txn(d, we, byt, a, wd, $urandom_range(0, 2), "rand", got, ge);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
